// File: rtl/mp64_crc_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mp64_crc_check : receive-side CRC32/CRC64 checker with MMIO status + IRQ  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mp64_crc_check #(
  parameter logic [63:0] DEFAULT_POLY = 64'h0000_0000_04C1_1DB7,
  parameter logic [63:0] DEFAULT_INIT = 64'h0000_0000_FFFF_FFFF,
  parameter int          CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [4:0]  addr_i,
  input  logic [63:0] wdata_i,
  input  logic        wen_i,
  output logic [63:0] rdata_o,
  output logic        ack_o,
  input  logic        s_valid_i,
  input  logic [7:0]  s_data_i,
  input  logic        s_last_i,
  output logic        s_ready_o,
  output logic        irq_o
);

  localparam logic [4:0] ADDR_POLY   = 5'h00;
  localparam logic [4:0] ADDR_INIT   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_CTRL   = 5'h18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        poly_q, poly_d;
  logic [63:0]        init_q, init_d;
  logic [63:0]        crc_q, crc_d;
  logic [63:0]        tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic               err_short_q, err_short_d;
  logic               crc64_q, crc64_d;
  logic               irq_en_q, irq_en_d;
  logic               w64_q, w64_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               ack_q;
  logic               irq_q, irq_d;
  logic               s_ready_q, s_ready_d;

  logic               wr, rd, ctrl_wr, arm, beat, busy, crc_eq;
  logic [CNT_W-1:0]   t_len;
  logic [7:0]         old_byte;
  logic [63:0]        status;

  // MSB-first bitwise CRC update; in 32-bit mode only crc[31:0] is meaningful.
  function automatic logic [63:0] crc_step(input logic [63:0] c, input logic [7:0] b,
                                           input logic [63:0] p, input logic w64);
    logic [63:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = (w64 ? r[63] : r[31]) ^ b[i];
      r  = {r[62:0], 1'b0};
      if (fb) r = r ^ p;
    end
    if (!w64) r[63:32] = 32'd0;
    return r;
  endfunction

  assign wr       = req_i & wen_i;
  assign rd       = req_i & ~wen_i;
  assign ctrl_wr  = wr && (addr_i == ADDR_CTRL);
  assign arm      = ctrl_wr & wdata_i[2];
  assign beat     = s_valid_i & s_ready_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign t_len    = w64_q ? CNT_W'(8) : CNT_W'(4);
  assign old_byte = w64_q ? tail_q[63:56] : tail_q[31:24];
  assign crc_eq   = w64_q ? (crc_q == tail_q) : (crc_q[31:0] == tail_q[31:0]);

  always_comb begin
    status              = 64'd0;
    status[0]           = done_q;
    status[1]           = match_q;
    status[2]           = err_short_q;
    status[3]           = busy;
    status[16 +: CNT_W] = count_q;
  end

  always_comb begin
    state_d     = state_q;
    poly_d      = poly_q;
    init_d      = init_q;
    crc_d       = crc_q;
    tail_d      = tail_q;
    count_d     = count_q;
    done_d      = done_q;
    match_d     = match_q;
    err_short_d = err_short_q;
    crc64_d     = crc64_q;
    irq_en_d    = irq_en_q;
    w64_d       = w64_q;
    irq_d       = 1'b0;
    rdata_d     = 64'd0;

    if (wr && addr_i == ADDR_POLY) poly_d = wdata_i;
    if (wr && addr_i == ADDR_INIT) init_d = wdata_i;
    // crc64 is always stored but only takes effect when latched by an arm
    if (ctrl_wr) begin
      crc64_d  = wdata_i[0];
      irq_en_d = wdata_i[1];
    end

    if (arm) begin
      state_d     = ST_RUN;
      crc_d       = init_q;
      tail_d      = 64'd0;
      count_d     = '0;
      done_d      = 1'b0;
      match_d     = 1'b0;
      err_short_d = 1'b0;
      w64_d       = wdata_i[0];
    end else begin
      case (state_q)
        ST_RUN: begin
          if (beat) begin
            tail_d = {tail_q[55:0], s_data_i};
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
            // the trailer is held back in tail; bytes feed the CRC as they age out
            if (count_q >= t_len) crc_d = crc_step(crc_q, old_byte, poly_q, w64_q);
            if (s_last_i) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          match_d     = crc_eq && (count_q > t_len);
          err_short_d = !(count_q > t_len);
          done_d      = 1'b1;
          irq_d       = irq_en_q;
          state_d     = ST_DONE;
        end
        default: ;
      endcase
    end

    if (rd) begin
      case (addr_i)
        ADDR_POLY:   rdata_d = poly_q;
        ADDR_INIT:   rdata_d = init_q;
        ADDR_STATUS: rdata_d = status;
        ADDR_CTRL:   rdata_d = {61'd0, 1'b0, irq_en_q, crc64_q};
        default:     rdata_d = 64'd0;
      endcase
    end

    s_ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      poly_q      <= DEFAULT_POLY;
      init_q      <= DEFAULT_INIT;
      crc_q       <= 64'd0;
      tail_q      <= 64'd0;
      count_q     <= '0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      err_short_q <= 1'b0;
      crc64_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      w64_q       <= 1'b0;
      rdata_q     <= 64'd0;
      ack_q       <= 1'b0;
      irq_q       <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      poly_q      <= poly_d;
      init_q      <= init_d;
      crc_q       <= crc_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      done_q      <= done_d;
      match_q     <= match_d;
      err_short_q <= err_short_d;
      crc64_q     <= crc64_d;
      irq_en_q    <= irq_en_d;
      w64_q       <= w64_d;
      rdata_q     <= rdata_d;
      ack_q       <= req_i;
      irq_q       <= irq_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;
  assign irq_o     = irq_q;
  assign s_ready_o = s_ready_q;

endmodule
`default_nettype wire
